// File: rtl/regfile_write_ctrl_if.sv
// Bus bundle between the result producers / read path and the register-file
// write controller.
//   master : producer side (ALU, load unit) and read-path forwarding lookup
//   slave  : regfile_write_ctrl
// Signals:
//   alu_*     ALU result handshake (valid/ready, destination, data)
//   ld_*      load result handshake (valid/ready, destination, data)
//   fwd_*     forwarding lookup for the two read ports
//   init_busy register-file clear sequence in progress
//   reg_write / write_reg / write_data  register-file write port
interface regfile_write_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;

    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_reg;
    logic [DATA_W-1:0] ld_data;

    logic [ADDR_W-1:0] fwd_reg1;
    logic [ADDR_W-1:0] fwd_reg2;
    logic              fwd_hit1;
    logic [DATA_W-1:0] fwd_data1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data2;

    logic              init_busy;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;

    modport master (
        output alu_valid, alu_reg, alu_data,
        output ld_valid, ld_reg, ld_data,
        output fwd_reg1, fwd_reg2,
        input  alu_ready, ld_ready,
        input  fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
        input  init_busy, reg_write, write_reg, write_data
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  ld_valid, ld_reg, ld_data,
        input  fwd_reg1, fwd_reg2,
        output alu_ready, ld_ready,
        output fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
        output init_busy, reg_write, write_reg, write_data
    );
endinterface

// File: rtl/regfile_write_ctrl.sv
// Write-side controller for the register file.
// Clears every register after reset (the register file has no reset of its
// own), then accepts ALU and load results over valid/ready handshakes,
// queues them in order and retires one write per cycle. A combinational
// forwarding lookup exposes pending writes to the read path.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    regfile_write_ctrl_if.slave (handshakes, forwarding, write port)
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_INIT | writing zero to registers 0..NUM_REGS-1, producers held off
// ST_RUN  | accepting results, retiring one queued write per cycle
module regfile_write_ctrl #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16,
    parameter int QDEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_write_ctrl_if.slave  bus
);
    localparam int PTR_W  = $clog2(QDEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int INIT_W = $clog2(NUM_REGS + 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [INIT_W-1:0] init_cnt;
    logic              init_busy_q;
    logic              reg_write_q;
    logic [ADDR_W-1:0] write_reg_q;
    logic [DATA_W-1:0] write_data_q;

    logic [ADDR_W-1:0] q_reg  [QDEPTH];
    logic [DATA_W-1:0] q_data [QDEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  free;

    logic              run;
    logic              ld_ready;
    logic              alu_ready;
    logic              push_ld;
    logic              push_alu;
    logic              pop;
    logic [PTR_W-1:0]  alu_slot;

    assign run  = (state == ST_RUN);
    assign free = CNT_W'(QDEPTH) - count;

    // The ALU reserves a second slot whenever a load is offered, so a
    // simultaneous load can never be starved of space by the ALU.
    always_comb begin
        ld_ready  = run && (free >= CNT_W'(1));
        alu_ready = run && (bus.ld_valid ? (free >= CNT_W'(2)) : (free >= CNT_W'(1)));
    end

    // Register 0 results complete the handshake but are dropped here.
    assign push_ld  = bus.ld_valid  && ld_ready  && (bus.ld_reg  != '0);
    assign push_alu = bus.alu_valid && alu_ready && (bus.alu_reg != '0);
    assign pop      = run && (count != '0);
    // Load goes ahead of the ALU result when both arrive together.
    assign alu_slot = wr_ptr + PTR_W'(push_ld);

    always_ff @(posedge clk) begin
        if (push_ld) begin
            q_reg[wr_ptr]  <= bus.ld_reg;
            q_data[wr_ptr] <= bus.ld_data;
        end
        if (push_alu) begin
            q_reg[alu_slot]  <= bus.alu_reg;
            q_data[alu_slot] <= bus.alu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_INIT;
            init_cnt     <= '0;
            init_busy_q  <= 1'b1;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt < INIT_W'(NUM_REGS)) begin
                        reg_write_q  <= 1'b1;
                        write_reg_q  <= ADDR_W'(init_cnt);
                        write_data_q <= '0;
                        init_cnt     <= init_cnt + INIT_W'(1);
                    end else begin
                        reg_write_q <= 1'b0;
                        init_busy_q <= 1'b0;
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pop) begin
                        reg_write_q  <= 1'b1;
                        write_reg_q  <= q_reg[rd_ptr];
                        write_data_q <= q_data[rd_ptr];
                    end else begin
                        reg_write_q <= 1'b0;
                    end
                    rd_ptr <= rd_ptr + PTR_W'(pop);
                    wr_ptr <= wr_ptr + PTR_W'(push_ld) + PTR_W'(push_alu);
                    count  <= count + CNT_W'(push_ld) + CNT_W'(push_alu) - CNT_W'(pop);
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Forwarding: scan oldest to youngest (output stage, then head..tail)
    // so the last match found is the youngest pending write.
    logic [ADDR_W-1:0] fwd_idx  [2];
    logic              fwd_hit  [2];
    logic [DATA_W-1:0] fwd_data [2];
    logic [PTR_W-1:0]  fwd_slot;

    always_comb begin
        fwd_idx[0] = bus.fwd_reg1;
        fwd_idx[1] = bus.fwd_reg2;
        fwd_slot   = '0;
        for (int p = 0; p < 2; p++) begin
            fwd_hit[p]  = 1'b0;
            fwd_data[p] = '0;
            if (run && (fwd_idx[p] != '0)) begin
                if (reg_write_q && (write_reg_q == fwd_idx[p])) begin
                    fwd_hit[p]  = 1'b1;
                    fwd_data[p] = write_data_q;
                end
                for (int i = 0; i < QDEPTH; i++) begin
                    fwd_slot = rd_ptr + PTR_W'(i);
                    if ((CNT_W'(i) < count) && (q_reg[fwd_slot] == fwd_idx[p])) begin
                        fwd_hit[p]  = 1'b1;
                        fwd_data[p] = q_data[fwd_slot];
                    end
                end
            end
        end
    end

    assign bus.ld_ready   = ld_ready;
    assign bus.alu_ready  = alu_ready;
    assign bus.fwd_hit1   = fwd_hit[0];
    assign bus.fwd_data1  = fwd_data[0];
    assign bus.fwd_hit2   = fwd_hit[1];
    assign bus.fwd_data2  = fwd_data[1];
    assign bus.init_busy  = init_busy_q;
    assign bus.reg_write  = reg_write_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;
endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl: init clear, single and paired
// results, back-pressure ordering, register-0 discard and mid-run reset.
module tb_regfile_write_ctrl;
    localparam int DATA_W   = 4;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;
    localparam int QDEPTH   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    regfile_write_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    regfile_write_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_reg   = '0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_reg    = '0;
        bus.ld_data   = '0;
    endtask

    // Expects rst_n released just before the next edge.
    task automatic init_sequence(input string tag);
        for (int k = 0; k < NUM_REGS; k++) begin
            tick();
            check($sformatf("%s_rw%0d", tag, k), bus.reg_write, 1);
            check($sformatf("%s_wr%0d", tag, k), bus.write_reg, k);
            check($sformatf("%s_wd%0d", tag, k), bus.write_data, 0);
            check($sformatf("%s_busy%0d", tag, k), bus.init_busy, 1);
            check($sformatf("%s_ldr%0d", tag, k), bus.ld_ready, 0);
            check($sformatf("%s_alur%0d", tag, k), bus.alu_ready, 0);
            check($sformatf("%s_hit%0d", tag, k), bus.fwd_hit1, 0);
        end
        tick();
        idle_inputs();
        #1;
        check({tag, "_end_rw"}, bus.reg_write, 0);
        check({tag, "_end_busy"}, bus.init_busy, 0);
        check({tag, "_end_ldr"}, bus.ld_ready, 1);
        check({tag, "_end_alur"}, bus.alu_ready, 1);
    endtask

    logic [ADDR_W-1:0] ld_regs   [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    logic [DATA_W-1:0] ld_vals   [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    logic [ADDR_W-1:0] alu_regs  [4] = '{4'd6, 4'd7, 4'd8, 4'd9};
    logic [DATA_W-1:0] alu_vals  [4] = '{4'h8, 4'h9, 4'hA, 4'hB};
    logic [ADDR_W-1:0] exp_wreg  [8] = '{4'd1, 4'd6, 4'd2, 4'd7, 4'd3, 4'd4, 4'd8, 4'd9};
    logic [DATA_W-1:0] exp_wdata [8] = '{4'h1, 4'h8, 4'h2, 4'h9, 4'h3, 4'h4, 4'hA, 4'hB};
    logic              exp_ldr   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic              exp_alur  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  ld_i;
        int  alu_i;
        int  wi;
        logic acc_ld;
        logic acc_alu;

        idle_inputs();
        bus.fwd_reg1 = 4'd5;
        bus.fwd_reg2 = 4'd0;

        // Reset state
        #12;
        check("rst_rw", bus.reg_write, 0);
        check("rst_wr", bus.write_reg, 0);
        check("rst_wd", bus.write_data, 0);
        check("rst_busy", bus.init_busy, 1);
        check("rst_ldr", bus.ld_ready, 0);
        check("rst_alur", bus.alu_ready, 0);
        check("rst_hit", bus.fwd_hit1, 0);
        tick();
        rst_n = 1'b1;
        init_sequence("init");

        // Single ALU result and its forwarding window
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 4'd3;
        bus.alu_data  = 4'hA;
        bus.fwd_reg1  = 4'd3;
        #1;
        check("a3_ready", bus.alu_ready, 1);
        check("a3_prehit", bus.fwd_hit1, 0);
        tick();
        idle_inputs();
        #1;
        check("a3_q_hit", bus.fwd_hit1, 1);
        check("a3_q_data", bus.fwd_data1, 4'hA);
        check("a3_q_rw", bus.reg_write, 0);
        tick();
        check("a3_rw", bus.reg_write, 1);
        check("a3_wr", bus.write_reg, 3);
        check("a3_wd", bus.write_data, 4'hA);
        check("a3_o_hit", bus.fwd_hit1, 1);
        check("a3_o_data", bus.fwd_data1, 4'hA);
        tick();
        check("a3_done_rw", bus.reg_write, 0);
        check("a3_done_hit", bus.fwd_hit1, 0);
        check("a3_done_data", bus.fwd_data1, 0);

        // Load and ALU to the same register in one cycle
        bus.ld_valid  = 1'b1;
        bus.ld_reg    = 4'd5;
        bus.ld_data   = 4'h7;
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 4'd5;
        bus.alu_data  = 4'h2;
        bus.fwd_reg2  = 4'd5;
        #1;
        check("p5_ldr", bus.ld_ready, 1);
        check("p5_alur", bus.alu_ready, 1);
        tick();
        idle_inputs();
        #1;
        check("p5_q_hit", bus.fwd_hit2, 1);
        check("p5_q_data", bus.fwd_data2, 4'h2);
        tick();
        check("p5_rw0", bus.reg_write, 1);
        check("p5_wr0", bus.write_reg, 5);
        check("p5_wd0", bus.write_data, 4'h7);
        check("p5_d0", bus.fwd_data2, 4'h2);
        tick();
        check("p5_rw1", bus.reg_write, 1);
        check("p5_wr1", bus.write_reg, 5);
        check("p5_wd1", bus.write_data, 4'h2);
        check("p5_d1", bus.fwd_data2, 4'h2);
        tick();
        check("p5_done_rw", bus.reg_write, 0);
        check("p5_done_hit", bus.fwd_hit2, 0);

        // Both producers streaming: back-pressure and in-order retire
        ld_i  = 0;
        alu_i = 0;
        wi    = 0;
        for (int c = 0; c < 14; c++) begin
            bus.ld_valid  = (ld_i < 4);
            bus.ld_reg    = (ld_i < 4) ? ld_regs[ld_i] : '0;
            bus.ld_data   = (ld_i < 4) ? ld_vals[ld_i] : '0;
            bus.alu_valid = (alu_i < 4);
            bus.alu_reg   = (alu_i < 4) ? alu_regs[alu_i] : '0;
            bus.alu_data  = (alu_i < 4) ? alu_vals[alu_i] : '0;
            #1;
            if (c < 6) begin
                check($sformatf("fill_ldr%0d", c), bus.ld_ready, exp_ldr[c]);
                check($sformatf("fill_alur%0d", c), bus.alu_ready, exp_alur[c]);
            end
            acc_ld  = bus.ld_valid && bus.ld_ready;
            acc_alu = bus.alu_valid && bus.alu_ready;
            tick();
            if (acc_ld)  ld_i++;
            if (acc_alu) alu_i++;
            if (bus.reg_write) begin
                if (wi < 8) begin
                    check($sformatf("fill_wr%0d", wi), bus.write_reg, exp_wreg[wi]);
                    check($sformatf("fill_wd%0d", wi), bus.write_data, exp_wdata[wi]);
                end
                wi++;
            end
        end
        idle_inputs();
        check("fill_wr_count", wi, 8);

        // Register 0 results are accepted but never written or forwarded
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 4'd0;
        bus.alu_data  = 4'hF;
        bus.fwd_reg1  = 4'd0;
        #1;
        check("r0_alur", bus.alu_ready, 1);
        tick();
        idle_inputs();
        #1;
        check("r0_hit", bus.fwd_hit1, 0);
        check("r0_data", bus.fwd_data1, 0);
        tick();
        check("r0_rw", bus.reg_write, 0);

        // Discarded load must not displace the ALU result sharing its cycle
        bus.ld_valid  = 1'b1;
        bus.ld_reg    = 4'd0;
        bus.ld_data   = 4'h5;
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 4'd4;
        bus.alu_data  = 4'h6;
        tick();
        idle_inputs();
        tick();
        check("r0mix_rw", bus.reg_write, 1);
        check("r0mix_wr", bus.write_reg, 4);
        check("r0mix_wd", bus.write_data, 4'h6);
        tick();
        check("r0mix_done_rw", bus.reg_write, 0);

        // Reset with three entries pending
        bus.ld_valid  = 1'b1;
        bus.ld_reg    = 4'd10;
        bus.ld_data   = 4'h1;
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 4'd11;
        bus.alu_data  = 4'h2;
        tick();
        bus.ld_reg    = 4'd12;
        bus.ld_data   = 4'h3;
        bus.alu_reg   = 4'd13;
        bus.alu_data  = 4'h4;
        tick();
        idle_inputs();
        bus.fwd_reg1 = 4'd12;
        #1;
        check("mr_rw", bus.reg_write, 1);
        check("mr_wr", bus.write_reg, 10);
        check("mr_pre_hit", bus.fwd_hit1, 1);
        check("mr_pre_data", bus.fwd_data1, 4'h3);
        rst_n = 1'b0;
        #1;
        check("mr_rst_rw", bus.reg_write, 0);
        check("mr_rst_wr", bus.write_reg, 0);
        check("mr_rst_busy", bus.init_busy, 1);
        check("mr_rst_ldr", bus.ld_ready, 0);
        check("mr_rst_hit", bus.fwd_hit1, 0);
        tick();
        check("mr_hold_rw", bus.reg_write, 0);
        rst_n = 1'b1;
        // Producers keep offering during the clear; nothing may be taken.
        bus.ld_valid  = 1'b1;
        bus.ld_reg    = 4'd14;
        bus.ld_data   = 4'h9;
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 4'd15;
        bus.alu_data  = 4'h8;
        init_sequence("reinit");
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("mr_flushed_rw%0d", k), bus.reg_write, 0);
            check($sformatf("mr_flushed_wr%0d", k), bus.write_reg, 15);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
